// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU address-select stage and the data-memory responder.
// The responder uses slave; the requester, or a bench, uses master.
interface data_mem_responder_if #(
  parameter int DATA_W = 32
);
  logic              i_Req;
  logic              i_WrEn;
  logic [DATA_W-1:0] i_Addr;
  logic [DATA_W-1:0] i_WrData;
  logic              o_Ready;
  logic              o_Ack;
  logic [DATA_W-1:0] o_RdData;
  logic              o_AddrErr;

  modport slave (
    input  i_Req, i_WrEn, i_Addr, i_WrData,
    output o_Ready, o_Ack, o_RdData, o_AddrErr
  );

  modport master (
    output i_Req, i_WrEn, i_Addr, i_WrData,
    input  o_Ready, o_Ack, o_RdData, o_AddrErr
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word RAM responder for VeSPA loads/stores: one request per handshake, o_Ack WAIT_STATES cycles after accept.
// Backpressure: o_Ready is low from accept through the ack cycle; a request that is not accepted is dropped, so the requester holds i_Req.
module data_mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              wr_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept_d;
  logic              done_d;
  logic              wr_d;
  logic              in_range_d;
  logic [DATA_W-1:0] addr_d;
  logic [DATA_W-1:0] wdat_d;
  logic [ADDR_W-1:0] idx_d;

  // With zero wait states, completion happens on the accept edge itself, so the
  // live inputs are used instead of the latched copies.
  always_comb begin
    accept_d   = (state_q == S_IDLE) && bus.i_Req;
    wr_d       = accept_d ? bus.i_WrEn   : wr_q;
    addr_d     = accept_d ? bus.i_Addr   : addr_q;
    wdat_d     = accept_d ? bus.i_WrData : wdat_q;
    done_d     = (accept_d && (WAIT_STATES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    in_range_d = (addr_d[DATA_W-1:ADDR_W] == '0);
    idx_d      = addr_d[ADDR_W-1:0];
  end

  // RAM contents survive reset; the reset gate stops an aborted store from landing.
  always_ff @(posedge i_Clk) begin
    if (i_Rst && done_d && wr_d && in_range_d) begin
      mem[idx_d] <= wdat_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (accept_d) begin
        wr_q   <= bus.i_WrEn;
        addr_q <= bus.i_Addr;
        wdat_q <= bus.i_WrData;
      end
      if (done_d) begin
        state_q <= S_RESP;
        ack_q   <= 1'b1;
        err_q   <= !in_range_d;
        if (!wr_d) begin
          rdata_q <= in_range_d ? mem[idx_d] : '0;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept_d) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
          S_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
          end
          S_RESP: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_Ready   = (state_q == S_IDLE);
  assign bus.o_Ack     = ack_q;
  assign bus.o_RdData  = rdata_q;
  assign bus.o_AddrErr = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut1 runs with one wait state, dut0 with none; expected values are hand-computed constants.
module tb_data_mem_responder;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  data_mem_responder_if #(.DATA_W(32)) bus1 ();
  data_mem_responder_if #(.DATA_W(32)) bus0 ();

  data_mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(1)) dut1 (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus1)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(10), .WAIT_STATES(0)) dut0 (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .bus   (bus0)
  );

  // One complete transaction on dut1. After the accept edge the inputs are
  // scrambled so that any use of unlatched values shows up in a later check.
  // lat counts cycles from the request cycle to the ack cycle.
  task automatic op1(input string name, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdat, input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    @(posedge clk); #1;
    checks++;
    if (bus1.o_Ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready_idle got=%b exp=1", name, bus1.o_Ready);
    end
    bus1.i_Req = 1'b1; bus1.i_WrEn = wr; bus1.i_Addr = addr; bus1.i_WrData = wdat;
    @(posedge clk); #1;
    lat = 1;
    bus1.i_Req = 1'b0; bus1.i_WrEn = ~wr; bus1.i_Addr = addr ^ 32'h1; bus1.i_WrData = ~wdat;
    while (bus1.o_Ack !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      failures++; $display("FAIL %s_ack_latency got=%0d exp=2", name, lat);
    end
    checks++;
    if (bus1.o_Ready !== 1'b0) begin
      failures++; $display("FAIL %s_ready_on_ack got=%b exp=0", name, bus1.o_Ready);
    end
    checks++;
    if (bus1.o_AddrErr !== exp_err) begin
      failures++; $display("FAIL %s_addr_err got=%b exp=%b", name, bus1.o_AddrErr, exp_err);
    end
    checks++;
    if (bus1.o_RdData !== exp_rd) begin
      failures++; $display("FAIL %s_rd_data got=%h exp=%h", name, bus1.o_RdData, exp_rd);
    end
    @(posedge clk); #1;
    checks++;
    if (bus1.o_Ack !== 1'b0 || bus1.o_AddrErr !== 1'b0 || bus1.o_Ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_after_ack got ack=%b err=%b rdy=%b exp ack=0 err=0 rdy=1",
               name, bus1.o_Ack, bus1.o_AddrErr, bus1.o_Ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus1.o_Ready !== 1'b1 || bus1.o_Ack !== 1'b0 || bus1.o_RdData !== 32'h0 || bus1.o_AddrErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1 got rdy=%b ack=%b rd=%h err=%b exp 1 0 0 0",
               bus1.o_Ready, bus1.o_Ack, bus1.o_RdData, bus1.o_AddrErr);
    end
    checks++;
    if (bus0.o_Ready !== 1'b1 || bus0.o_Ack !== 1'b0 || bus0.o_RdData !== 32'h0 || bus0.o_AddrErr !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0 got rdy=%b ack=%b rd=%h err=%b exp 1 0 0 0",
               bus0.o_Ready, bus0.o_Ack, bus0.o_RdData, bus0.o_AddrErr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus1.o_Ready !== 1'b1 || bus1.o_Ack !== 1'b0) begin
      failures++; $display("FAIL reset_release got rdy=%b ack=%b exp rdy=1 ack=0", bus1.o_Ready, bus1.o_Ack);
    end
  endtask

  task automatic test_store_load();
    op1("st_005", 1'b1, 32'h005, 32'hDEADBEEF, 32'h0, 1'b0);
    op1("ld_005", 1'b0, 32'h005, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  // dut0 with i_Req held: an ack every second cycle and o_Ready low on each ack.
  task automatic test_back_to_back();
    logic        wr_t [4];
    logic [31:0] ad_t [4];
    logic [31:0] wd_t [4];
    logic [31:0] rd_t [4];
    int          op;
    logic        exp_ack;
    wr_t = '{1'b1, 1'b1, 1'b0, 1'b0};
    ad_t = '{32'h000, 32'h3FF, 32'h000, 32'h3FF};
    wd_t = '{32'h00C0FFEE, 32'hFEEDF00D, 32'h0, 32'h0};
    rd_t = '{32'h0, 32'h0, 32'h00C0FFEE, 32'hFEEDF00D};
    @(posedge clk); #1;
    op = 0;
    bus0.i_Req = 1'b1; bus0.i_WrEn = wr_t[0]; bus0.i_Addr = ad_t[0]; bus0.i_WrData = wd_t[0];
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 1);
      checks++;
      if (bus0.o_Ack !== exp_ack || bus0.o_Ready !== !exp_ack) begin
        failures++;
        $display("FAIL b2b_handshake cyc=%0d got ack=%b rdy=%b exp ack=%b rdy=%b",
                 i, bus0.o_Ack, bus0.o_Ready, exp_ack, !exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (bus0.o_RdData !== rd_t[op] || bus0.o_AddrErr !== 1'b0) begin
          failures++;
          $display("FAIL b2b_data op=%0d got rd=%h err=%b exp rd=%h err=0",
                   op, bus0.o_RdData, bus0.o_AddrErr, rd_t[op]);
        end
        op++;
        if (op < 4) begin
          bus0.i_WrEn = wr_t[op]; bus0.i_Addr = ad_t[op]; bus0.i_WrData = wd_t[op];
        end else begin
          bus0.i_Req = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    checks++;
    if (bus0.o_Ack !== 1'b0 || bus0.o_Ready !== 1'b1) begin
      failures++; $display("FAIL b2b_idle got ack=%b rdy=%b exp ack=0 rdy=1", bus0.o_Ack, bus0.o_Ready);
    end
  endtask

  task automatic test_range();
    op1("st_000", 1'b1, 32'h000, 32'hCAFE0000, 32'hDEADBEEF, 1'b0);
    op1("ld_400", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
    op1("st_400", 1'b1, 32'h400, 32'h00001234, 32'h0, 1'b1);
    op1("ld_000", 1'b0, 32'h000, 32'h0, 32'hCAFE0000, 1'b0);
  endtask

  task automatic test_reset_abort();
    int saw_ack;
    op1("st_010", 1'b1, 32'h010, 32'h0BADF00D, 32'hCAFE0000, 1'b0);
    @(posedge clk); #1;
    bus1.i_Req = 1'b1; bus1.i_WrEn = 1'b1; bus1.i_Addr = 32'h010; bus1.i_WrData = 32'hAAAA5555;
    @(posedge clk); #1;
    bus1.i_Req = 1'b0;
    checks++;
    if (bus1.o_Ready !== 1'b0) begin
      failures++; $display("FAIL abort_in_wait got rdy=%b exp=0", bus1.o_Ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus1.o_Ready !== 1'b1 || bus1.o_Ack !== 1'b0 || bus1.o_RdData !== 32'h0) begin
      failures++;
      $display("FAIL abort_reset got rdy=%b ack=%b rd=%h exp rdy=1 ack=0 rd=0",
               bus1.o_Ready, bus1.o_Ack, bus1.o_RdData);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    saw_ack = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus1.o_Ack !== 1'b0 || bus1.o_Ready !== 1'b1) saw_ack++;
    end
    checks++;
    if (saw_ack != 0) begin
      failures++; $display("FAIL abort_no_ack got bad_cycles=%0d exp=0", saw_ack);
    end
    op1("ld_010", 1'b0, 32'h010, 32'h0, 32'h0BADF00D, 1'b0);
  endtask

  task automatic test_latch();
    op1("st_021", 1'b1, 32'h021, 32'h5A5A0000, 32'h0BADF00D, 1'b0);
    op1("st_020", 1'b1, 32'h020, 32'h11112222, 32'h0BADF00D, 1'b0);
    op1("ld_020", 1'b0, 32'h020, 32'h0, 32'h11112222, 1'b0);
    op1("ld_021", 1'b0, 32'h021, 32'h0, 32'h5A5A0000, 1'b0);
  endtask

  initial begin
    bus1.i_Req = 1'b0; bus1.i_WrEn = 1'b0; bus1.i_Addr = '0; bus1.i_WrData = '0;
    bus0.i_Req = 1'b0; bus0.i_WrEn = 1'b0; bus0.i_Addr = '0; bus0.i_WrData = '0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_range();
    test_reset_abort();
    test_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
